fifo_burst_reader: RTL

//  Read-side master for ring_buffer: drains a requested number of entries from the buffer's

---
 rtl/fifo_pkg.sv | 11 +
 rtl/stream_out_reg.sv | 36 +++
 rtl/fifo_burst_reader.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the ring_buffer burst masters (reader now, writer later).
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } burst_rd_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register. A held beat stays stable until accepted.
// o_can_load tells the master a new beat may be loaded this cycle.
module stream_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_can_load
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Load wins over accept so a simultaneous accept+load streams back-to-back.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for ring_buffer: pops burst_len beats from the
// combinational head and streams them out through a one-entry register.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] fifo_head,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  remaining
);

  burst_rd_state_t      r_state, w_next;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_aborted;
  logic                 r_done;
  logic                 w_can_load;
  logic                 w_pop;
  logic                 w_start_ok;
  logic                 w_last;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_last     = (r_remaining == LEN_WIDTH'(1));

  // Pop only when the output register can take the beat; gated by reset so
  // nothing leaves the buffer while rst_n is low.
  assign w_pop = rst_n && (r_state == RUN) && !abort && !fifo_empty &&
                 (r_remaining != '0) && w_can_load;

  stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_pop),
    .i_data     (fifo_head),
    .i_ready    (m_ready),
    .o_valid    (m_valid),
    .o_data     (m_data),
    .o_can_load (w_can_load)
  );

  // Next-state logic; an empty buffer in RUN simply stalls with no timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (burst_len == '0) ? DONE : RUN;
      RUN:     if (abort) w_next = DRAIN;
               else if (w_pop && w_last) w_next = DRAIN;
      DRAIN:   if (!m_valid || m_ready) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and registered done pulse (high exactly while in DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == DONE);
    end
  end

  // Beat counter: loaded on an accepted start, decremented per pop.
  always_ff @(posedge clk) begin
    if (!rst_n)          r_remaining <= '0;
    else if (w_start_ok) r_remaining <= burst_len;
    else if (w_pop)      r_remaining <= r_remaining - LEN_WIDTH'(1);
  end

  // Abort flag: cleared by a new burst, set only by an abort seen in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n)                         r_aborted <= 1'b0;
    else if (w_start_ok)                r_aborted <= 1'b0;
    else if (r_state == RUN && abort)   r_aborted <= 1'b1;
  end

  assign fifo_pop  = w_pop;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign remaining = r_remaining;

endmodule
